// File: rtl/ce_gen_pkg.sv
// Shared types, defaults and helpers for the fractional clock-enable generator.
package ce_gen_pkg;

    localparam int CE_DEF_NUM = 1;
    localparam int CE_DEF_DEN = 6;
    // Widest NUM/DEN any instance may use; narrower instances zero-extend.
    localparam int CE_MAX_W   = 32;

    typedef struct packed {
        logic [CE_MAX_W-1:0] num;
        logic [CE_MAX_W-1:0] den;
    } ce_cfg_t;

    // A numerator above the denominator saturates to "enable every cycle".
    function automatic logic [CE_MAX_W-1:0] effective_num(input ce_cfg_t cfg);
        return (cfg.num > cfg.den) ? cfg.den : cfg.num;
    endfunction

    function automatic int ce_ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/ce_gen_if.sv
// Configuration/strobe bus and enable outputs of ce_gen.
interface ce_gen_if
    import ce_gen_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 8
) ();
    localparam int CH_W = ce_ch_w(CHANNELS);

    logic                sync;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [DIV_W-1:0]    cfg_num;
    logic [DIV_W-1:0]    cfg_den;
    logic [CHANNELS-1:0] ce;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] active;

    modport master (
        output sync, cfg_we, cfg_ch, cfg_num, cfg_den,
        input  ce, pending, active
    );

    modport slave (
        input  sync, cfg_we, cfg_ch, cfg_num, cfg_den,
        output ce, pending, active
    );

endinterface

// File: rtl/ce_gen_chan.sv
// One fractional enable channel: accumulator, pending config and boundary switch.
module ce_gen_chan
    import ce_gen_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DEF_NUM = CE_DEF_NUM,
    parameter int DEF_DEN = CE_DEF_DEN
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_num,
    input  logic [DIV_W-1:0] cfg_den,
    output logic             ce,
    output logic             pending,
    output logic             active
);

    logic [DIV_W-1:0] num_reg,  num_next;
    logic [DIV_W-1:0] den_reg,  den_next;
    logic [DIV_W-1:0] pnum_reg, pnum_next;
    logic [DIV_W-1:0] pden_reg, pden_next;
    logic [DIV_W-1:0] acc_reg,  acc_next;
    logic             pend_reg, pend_next;
    logic             ce_reg,   ce_next;

    ce_cfg_t          live_cfg;
    logic [DIV_W-1:0] eff_num;
    logic [DIV_W:0]   sum;
    logic             live_active;
    logic             hit;
    logic             apply;

    always_comb begin
        live_cfg.num = CE_MAX_W'(num_reg);
        live_cfg.den = CE_MAX_W'(den_reg);
        eff_num      = DIV_W'(effective_num(live_cfg));
        live_active  = (num_reg != '0) && (den_reg != '0);
        sum          = {1'b0, acc_reg} + {1'b0, eff_num};
        hit          = live_active && (sum >= {1'b0, den_reg});
        // Switch only where a pulse is being emitted, so no period is cut short.
        apply        = pend_reg && (sync || hit || !live_active);
    end

    always_comb begin
        num_next  = num_reg;
        den_next  = den_reg;
        pnum_next = pnum_reg;
        pden_next = pden_reg;
        acc_next  = acc_reg;
        pend_next = pend_reg;
        ce_next   = 1'b0;

        if (sync) begin
            acc_next = '0;
        end else if (live_active) begin
            ce_next  = hit;
            acc_next = hit ? DIV_W'(sum - {1'b0, den_reg}) : DIV_W'(sum);
        end else begin
            acc_next = '0;
        end

        if (apply) begin
            num_next  = pnum_reg;
            den_next  = pden_reg;
            acc_next  = '0;
            pend_next = 1'b0;
        end

        // A write landing on a boundary edge queues behind the value being applied.
        if (cfg_we) begin
            pnum_next = cfg_num;
            pden_next = cfg_den;
            pend_next = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            num_reg  <= DIV_W'(DEF_NUM);
            den_reg  <= DIV_W'(DEF_DEN);
            pnum_reg <= '0;
            pden_reg <= '0;
            acc_reg  <= '0;
            pend_reg <= 1'b0;
            ce_reg   <= 1'b0;
        end else begin
            num_reg  <= num_next;
            den_reg  <= den_next;
            pnum_reg <= pnum_next;
            pden_reg <= pden_next;
            acc_reg  <= acc_next;
            pend_reg <= pend_next;
            ce_reg   <= ce_next;
        end
    end

    assign ce      = ce_reg;
    assign pending = pend_reg;
    assign active  = live_active;

endmodule

// File: rtl/ce_gen.sv
// Multi-channel fractional clock-enable generator: per-channel NUM/DEN enables.
module ce_gen
    import ce_gen_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 8,
    parameter int DEF_NUM  = CE_DEF_NUM,
    parameter int DEF_DEN  = CE_DEF_DEN
) (
    input  logic     clk_sys,
    input  logic     reset,
    ce_gen_if.slave  bus
);

    localparam int CH_W = ce_ch_w(CHANNELS);

    logic [CHANNELS-1:0] chan_we;
    logic [CHANNELS-1:0] ce_w;
    logic [CHANNELS-1:0] pending_w;
    logic [CHANNELS-1:0] active_w;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            // Out-of-range channel indices match no instance and are dropped.
            assign chan_we[gi] = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));

            ce_gen_chan #(
                .DIV_W   (DIV_W),
                .DEF_NUM (DEF_NUM),
                .DEF_DEN (DEF_DEN)
            ) u_chan (
                .clk_sys (clk_sys),
                .reset   (reset),
                .sync    (bus.sync),
                .cfg_we  (chan_we[gi]),
                .cfg_num (bus.cfg_num),
                .cfg_den (bus.cfg_den),
                .ce      (ce_w[gi]),
                .pending (pending_w[gi]),
                .active  (active_w[gi])
            );
        end
    endgenerate

    assign bus.ce      = ce_w;
    assign bus.pending = pending_w;
    assign bus.active  = active_w;

endmodule

// File: tb/tb_ce_gen.sv
// Randomised and directed bench for ce_gen with a queue-based scoreboard.
module tb_ce_gen;
    import ce_gen_pkg::*;

    localparam int CHANNELS = 3;
    localparam int DIV_W    = 8;
    localparam int DEF_NUM  = 1;
    localparam int DEF_DEN  = 6;
    localparam int CH_W     = ce_ch_w(CHANNELS);

    logic clk_sys = 1'b0;
    logic reset;

    ce_gen_if #(.CHANNELS(CHANNELS), .DIV_W(DIV_W)) bus ();

    ce_gen #(
        .CHANNELS (CHANNELS),
        .DIV_W    (DIV_W),
        .DEF_NUM  (DEF_NUM),
        .DEF_DEN  (DEF_DEN)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int                  cyc;
        logic [CHANNELS-1:0] ce;
        logic [CHANNELS-1:0] pending;
        logic [CHANNELS-1:0] active;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: rational rate NUM/DEN tracked as a plain integer remainder.
    int m_num [CHANNELS];
    int m_den [CHANNELS];
    int m_pnum[CHANNELS];
    int m_pden[CHANNELS];
    int m_rem [CHANNELS];
    bit m_pend[CHANNELS];
    bit m_ce  [CHANNELS];

    task automatic check(input string name, input int at, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, at, got, want);
        end
    endtask

    task automatic model_step(input bit rst, input bit syn, input bit we,
                              input int ch, input int num, input int den);
        for (int c = 0; c < CHANNELS; c++) begin
            bit take;
            int rate;
            if (rst) begin
                m_num[c]  = DEF_NUM;
                m_den[c]  = DEF_DEN;
                m_rem[c]  = 0;
                m_pend[c] = 0;
                m_ce[c]   = 0;
            end else begin
                take = 0;
                if (syn) begin
                    m_rem[c] = 0;
                    m_ce[c]  = 0;
                    take     = m_pend[c];
                end else if (m_num[c] == 0 || m_den[c] == 0) begin
                    m_rem[c] = 0;
                    m_ce[c]  = 0;
                    take     = m_pend[c];
                end else begin
                    rate     = (m_num[c] > m_den[c]) ? m_den[c] : m_num[c];
                    m_rem[c] = m_rem[c] + rate;
                    m_ce[c]  = (m_rem[c] >= m_den[c]);
                    if (m_ce[c]) begin
                        m_rem[c] = m_rem[c] - m_den[c];
                        take     = m_pend[c];
                    end
                end
                if (take) begin
                    m_num[c]  = m_pnum[c];
                    m_den[c]  = m_pden[c];
                    m_rem[c]  = 0;
                    m_pend[c] = 0;
                end
                if (we && ch == c) begin
                    m_pnum[c] = num;
                    m_pden[c] = den;
                    m_pend[c] = 1;
                end
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit syn, input bit we,
                         input int ch, input int num, input int den);
        exp_t e;
        reset       = rst;
        bus.sync    = syn;
        bus.cfg_we  = we;
        bus.cfg_ch  = CH_W'(ch);
        bus.cfg_num = DIV_W'(num);
        bus.cfg_den = DIV_W'(den);
        if (rst || syn || we)
            $display("txn cyc=%0d reset=%0d sync=%0d we=%0d ch=%0d num=%0d den=%0d",
                     cyc, rst, syn, we, ch, num, den);
        model_step(rst, syn, we, ch, num, den);
        e.cyc = cyc;
        for (int c = 0; c < CHANNELS; c++) begin
            e.ce[c]      = m_ce[c];
            e.pending[c] = m_pend[c];
            e.active[c]  = (m_num[c] != 0) && (m_den[c] != 0);
        end
        exp_q.push_back(e);
        @(posedge clk_sys);
        #2;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge.
    always @(posedge clk_sys) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ce",      e.cyc, int'(bus.ce),      int'(e.ce));
            check("pending", e.cyc, int'(bus.pending), int'(e.pending));
            check("active",  e.cyc, int'(bus.active),  int'(e.active));
        end
    end

    initial begin
        int cnt;
        int budget;
        int den_r;

        repeat (3) cycle(1, 0, 0, 0, 0, 0);

        // Default /6 cadence: pulses on edges 6..60.
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            idle(1);
            cnt += int'(bus.ce[0]);
        end
        check("ce0_pulses_60", cyc, cnt, 10);
        check("ce0_edge60", cyc, int'(bus.ce[0]), 1);

        // Channel 1 to 2/5: exactly 8 pulses in any 20-cycle span after the switch.
        cycle(0, 0, 1, 1, 2, 5);
        idle(6);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            cnt += int'(bus.ce[1]);
        end
        check("ce1_pulses_2of5", cyc, cnt, 8);

        // Writes inside a /6 period; last write wins at the boundary.
        cycle(0, 0, 1, 0, 1, 4);
        idle(1);
        cycle(0, 0, 1, 0, 1, 8);
        idle(30);

        // Out-of-range channel index is ignored.
        cycle(0, 0, 1, 3, 1, 2);
        idle(3);

        // sync mid-period with /6 and /10 channels.
        cycle(0, 0, 1, 0, 1, 6);
        cycle(0, 0, 1, 1, 1, 10);
        idle(13);
        cycle(0, 1, 0, 0, 0, 0);
        idle(25);

        // Disabled channel, then re-enabled through the inactive boundary.
        cycle(0, 0, 1, 0, 0, 6);
        idle(12);
        check("ch0_inactive", cyc, int'(bus.active[0]), 0);
        cycle(0, 0, 1, 0, 1, 3);
        idle(10);

        // Clamp num > den: enable held high.
        cycle(0, 0, 1, 2, 9, 4);
        idle(10);

        // Reset while a write is pending.
        cycle(0, 0, 1, 1, 3, 7);
        cycle(1, 0, 0, 0, 0, 0);
        check("pending_after_reset", cyc, int'(bus.pending), 0);
        idle(14);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            bit rst_r, syn_r, we_r;
            rst_r = ($urandom_range(0, 199) == 0);
            syn_r = ($urandom_range(0, 39) == 0);
            we_r  = ($urandom_range(0, 7) == 0);
            den_r = $urandom_range(0, 12);
            cycle(rst_r, syn_r, we_r, $urandom_range(0, 3),
                  $urandom_range(0, den_r + 2), den_r);
        end
        idle(2);

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk_sys);
            budget--;
        end
        #2;
        check("scoreboard_drained", cyc, exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
